ibex_dmem_req: RTL

IBEX_DMEM_REQ -- requirements
Module: ibex_dmem_req

---
 rtl/ibex_dmem_req.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ibex_dmem_req.sv
// LSU-to-SRAM data request sequencer: splits misaligned accesses into two word
// transactions, steers byte lanes, and assembles/sign-extends load results.
module ibex_dmem_req #(
    parameter int unsigned SRAM_AW = 10
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_we_i,
    input  logic [1:0]         cmd_type_i,
    input  logic               cmd_sext_i,
    input  logic [31:0]        cmd_addr_i,
    input  logic [31:0]        cmd_wdata_i,
    output logic               resp_valid_o,
    output logic [31:0]        resp_rdata_o,
    output logic               resp_split_o,
    output logic               sram_req_o,
    output logic               sram_we_o,
    output logic [3:0]         sram_be_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [31:0]        sram_wdata_o,
    input  logic               sram_gnt_i,
    input  logic               sram_rvalid_i,
    input  logic [31:0]        sram_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ1, S_WAIT1, S_REQ2, S_WAIT2, S_RESP
    } state_t;

    state_t r_state, w_next;

    logic               r_we, r_sext, r_split, r_sram_req, r_sram_we;
    logic [1:0]         r_type, r_off;
    logic [3:0]         r_be_hi, r_sram_be;
    logic [31:0]        r_wdata_hi, r_sram_wdata, r_rd1, r_rd2;
    logic [SRAM_AW-1:0] r_sram_addr;

    logic [1:0]  w_off;
    logic [3:0]  w_mask;
    logic [7:0]  w_lanes;
    logic [63:0] w_wdata64;
    logic [31:0] w_rdw, w_ld;
    logic        w_unused_addr;

    assign w_off         = cmd_addr_i[1:0];
    assign w_lanes       = {4'b0000, w_mask} << w_off;
    assign w_wdata64     = {32'h0, cmd_wdata_i} << {w_off, 3'b000};
    assign w_unused_addr = ^cmd_addr_i[31:SRAM_AW+2];

    always_comb begin
        w_mask = 4'b1111;
        case (cmd_type_i)
            2'b10:   w_mask = 4'b0001;
            2'b01:   w_mask = 4'b0011;
            default: w_mask = 4'b1111;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid_i)   w_next = S_REQ1;
            S_REQ1:  if (sram_gnt_i)    w_next = S_WAIT1;
            S_WAIT1: if (sram_rvalid_i) w_next = r_split ? S_REQ2 : S_RESP;
            S_REQ2:  if (sram_gnt_i)    w_next = S_WAIT2;
            S_WAIT2: if (sram_rvalid_i) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Lanes spilling past bit 3 of the shifted mask are what force a second transaction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_sext       <= 1'b0;
            r_split      <= 1'b0;
            r_type       <= '0;
            r_off        <= '0;
            r_be_hi      <= '0;
            r_wdata_hi   <= '0;
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_sram_req   <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_be    <= '0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
        end else begin
            r_state    <= w_next;
            r_sram_req <= (w_next == S_REQ1) || (w_next == S_REQ2);
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_we         <= cmd_we_i;
                        r_type       <= cmd_type_i;
                        r_sext       <= cmd_sext_i;
                        r_off        <= w_off;
                        r_split      <= |w_lanes[7:4];
                        r_be_hi      <= w_lanes[7:4];
                        r_wdata_hi   <= w_wdata64[63:32];
                        r_rd1        <= '0;
                        r_rd2        <= '0;
                        r_sram_we    <= cmd_we_i;
                        r_sram_be    <= w_lanes[3:0];
                        r_sram_addr  <= cmd_addr_i[SRAM_AW+1:2];
                        r_sram_wdata <= w_wdata64[31:0];
                    end
                end
                S_WAIT1: begin
                    if (sram_rvalid_i) begin
                        r_rd1 <= sram_rdata_i;
                        if (r_split) begin
                            r_sram_be    <= r_be_hi;
                            r_sram_addr  <= r_sram_addr + 1'b1;
                            r_sram_wdata <= r_wdata_hi;
                        end
                    end
                end
                S_WAIT2: begin
                    if (sram_rvalid_i) r_rd2 <= sram_rdata_i;
                end
                default: ;
            endcase
        end
    end

    assign w_rdw = 32'({r_rd2, r_rd1} >> {r_off, 3'b000});

    always_comb begin
        w_ld = w_rdw;
        case (r_type)
            2'b10:   w_ld = {{24{r_sext & w_rdw[7]}}, w_rdw[7:0]};
            2'b01:   w_ld = {{16{r_sext & w_rdw[15]}}, w_rdw[15:0]};
            default: w_ld = w_rdw;
        endcase
    end

    assign cmd_ready_o  = rst_ni && (r_state == S_IDLE);
    assign resp_valid_o = (r_state == S_RESP);
    assign resp_rdata_o = (resp_valid_o && !r_we) ? w_ld : '0;
    assign resp_split_o = resp_valid_o && r_split;
    assign sram_req_o   = r_sram_req;
    assign sram_we_o    = r_sram_we;
    assign sram_be_o    = r_sram_be;
    assign sram_addr_o  = r_sram_addr;
    assign sram_wdata_o = r_sram_wdata;

endmodule
